// File: rtl/mau_pkg.sv
// Shared definitions for the matrix algebra unit: opcodes, FSM encoding,
// elaboration helpers and the element add/sub arithmetic.
package mau_pkg;

  localparam logic [3:0] OP_NOP       = 4'b0000;
  localparam logic [3:0] OP_LOAD      = 4'b0100;
  localparam logic [3:0] OP_COPY      = 4'b0101;
  localparam logic [3:0] OP_UNLOAD    = 4'b0110;
  localparam logic [3:0] OP_CLEAR     = 4'b0111;
  localparam logic [3:0] OP_ADD       = 4'b1100;
  localparam logic [3:0] OP_SUB       = 4'b1101;
  localparam logic [3:0] OP_TRANSPOSE = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Ceiling log2, used at elaboration time for address and bank widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Unsigned add/sub of w-bit operands (w <= 32) carried in w+1 bits.
  // Bit w is the carry (add) or borrow (sub); with sat set it clamps the
  // result to all-ones (add) or zero (sub), otherwise the result wraps.
  function automatic logic [31:0] addsub_sat(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sub,
                                             input logic        sat,
                                             input int          w);
    logic [32:0] s;
    logic [32:0] mask;
    s    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    mask = (33'd1 << w) - 33'd1;
    if (sat && s[w]) return sub ? 32'd0 : mask[31:0];
    return 32'(s & mask);
  endfunction

endpackage

// File: rtl/mau_bank_mem.sv
// One matrix bank: DEPTH x DATA_W storage with a synchronous write port and
// a registered read port (one cycle of read latency).
module mau_bank_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed element and register the read element every cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mau_matrix_engine.sv
// Matrix algebra unit: NUM_BANKS banks of DIM x DIM elements, processed one
// element per cycle under host instructions {dst, src, opcode}.
module mau_matrix_engine
  import mau_pkg::*;
#(
  parameter int  DIM       = 8,
  parameter int  DATA_W    = 8,
  parameter int  NUM_BANKS = 4,
  parameter int  SAT       = 0,
  localparam int BANK_W    = clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*BANK_W+3:0]   host_instruction,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_in_valid,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_out_valid,
  output logic                  busy_flag,
  output logic                  cmd_error
);

  localparam int N      = DIM * DIM;
  localparam int ADDR_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int RC_W   = (clog2(DIM) < 1) ? 1 : clog2(DIM);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N - 1);
  localparam logic [RC_W-1:0]   C_LAST = RC_W'(DIM - 1);

  logic [3:0]        opcode;
  logic [BANK_W-1:0] src_in, dst_in;
  assign {dst_in, src_in, opcode} = host_instruction;

  state_t            state;
  logic [3:0]        op_q;
  logic [BANK_W-1:0] src_q, dst_q;
  logic [ADDR_W-1:0] k;
  logic [RC_W-1:0]   r, c;
  logic [ADDR_W-1:0] tk;

  logic              vld_p0;
  logic [ADDR_W-1:0] wk_p0;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata [NUM_BANKS];
  logic [DATA_W-1:0] src_data, dst_data;

  // Transposed read address: element (r, c) of dst comes from (c, r) of src.
  assign tk = ADDR_W'(int'(c) * DIM + int'(r));

  // Command FSM: accepts instructions in IDLE, steps the element counters
  // and drives the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      busy_flag      <= 1'b0;
      cmd_error      <= 1'b0;
      data_out_valid <= 1'b0;
    end else begin
      cmd_error      <= 1'b0;
      data_out_valid <= (state == ST_RUN) && (op_q == OP_UNLOAD);
      case (state)
        ST_IDLE: begin
          k     <= '0;
          r     <= '0;
          c     <= '0;
          op_q  <= opcode;
          src_q <= src_in;
          dst_q <= dst_in;
          case (opcode)
            OP_LOAD: begin
              state     <= ST_LOAD;
              busy_flag <= 1'b1;
            end
            OP_COPY, OP_TRANSPOSE: begin
              if (src_in == dst_in) begin
                cmd_error <= 1'b1;
              end else begin
                state     <= ST_RUN;
                busy_flag <= 1'b1;
              end
            end
            OP_UNLOAD, OP_CLEAR, OP_ADD, OP_SUB: begin
              state     <= ST_RUN;
              busy_flag <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_LOAD: begin
          if (data_in_valid) begin
            if (k == K_LAST) begin
              state     <= ST_IDLE;
              busy_flag <= 1'b0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (k == K_LAST) begin
            state <= ST_DRAIN;
          end else begin
            k <= k + 1'b1;
            if (c == C_LAST) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          state     <= ST_IDLE;
          busy_flag <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: read address issued this cycle, its data returns next cycle.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= (state == ST_RUN);
  end

  // Element index travelling with the read so the write lands one cycle later.
  always_ff @(posedge clk) begin
    wk_p0 <= k;
  end

  assign src_data = rdata[src_q];
  assign dst_data = rdata[dst_q];

  // Stage p1: form the dst write from returned read data or the host stream.
  always_comb begin
    we    = 1'b0;
    waddr = wk_p0;
    wdata = '0;
    if (state == ST_LOAD) begin
      we    = data_in_valid;
      waddr = k;
      wdata = data_in;
    end else if (vld_p0) begin
      case (op_q)
        OP_COPY, OP_TRANSPOSE: begin
          we    = 1'b1;
          wdata = src_data;
        end
        OP_CLEAR: begin
          we    = 1'b1;
          wdata = '0;
        end
        OP_ADD: begin
          we    = 1'b1;
          wdata = DATA_W'(addsub_sat(32'(dst_data), 32'(src_data), 1'b0,
                                     (SAT != 0), DATA_W));
        end
        OP_SUB: begin
          we    = 1'b1;
          wdata = DATA_W'(addsub_sat(32'(dst_data), 32'(src_data), 1'b1,
                                     (SAT != 0), DATA_W));
        end
        default: ;
      endcase
    end
    if (rst) we = 1'b0;
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [ADDR_W-1:0] raddr_g;
    logic              we_g;
    assign raddr_g = ((op_q == OP_TRANSPOSE) && (src_q == BANK_W'(g))) ? tk : k;
    assign we_g    = we && (dst_q == BANK_W'(g));
    mau_bank_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (N),
      .ADDR_W (ADDR_W)
    ) u_mem (
      .clk   (clk),
      .we    (we_g),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr_g),
      .rdata (rdata[g])
    );
  end

  assign data_out = data_out_valid ? dst_data : '0;

endmodule
